// File: rtl/stats_accumulate.sv
// stats_accumulate: per-ID statistics counters in distributed RAM fed by an increment stream, with a read port
module stats_accumulate #(
    parameter int STAT_INC_WIDTH   = 16,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 32,
    parameter bit CLEAR_ON_READ    = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [STAT_INC_WIDTH-1:0]   s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]    s_axis_stat_tid,
    input  logic                        s_axis_stat_tvalid,
    output logic                        s_axis_stat_tready,
    input  logic [STAT_ID_WIDTH-1:0]    rd_addr,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    output logic [STAT_COUNT_WIDTH-1:0] rd_data,
    output logic                        rd_data_valid,
    input  logic                        rd_data_ready,
    output logic                        busy
);
    localparam int DEPTH = 2**STAT_ID_WIDTH;

    typedef enum logic [1:0] {INIT, IDLE, UPDATE, READ_RESP} state_t;

    state_t                      state;
    logic [STAT_COUNT_WIDTH-1:0] mem [DEPTH];
    logic [STAT_ID_WIDTH-1:0]    init_ptr;
    logic [STAT_ID_WIDTH-1:0]    id_q;
    logic [STAT_INC_WIDTH-1:0]   inc_q;
    logic [STAT_COUNT_WIDTH-1:0] val_q;
    logic                        rr_rd;
    logic                        clr_first;
    logic                        grant_rd;
    logic                        grant_inc;
    logic                        mem_we;
    logic [STAT_ID_WIDTH-1:0]    mem_waddr;
    logic [STAT_COUNT_WIDTH-1:0] mem_wdata;

    // Arbitration between read and increment, plus the single RAM write port mux
    always_comb begin
        grant_rd  = state == IDLE && rd_valid && (rr_rd || !s_axis_stat_tvalid);
        grant_inc = state == IDLE && s_axis_stat_tvalid && !grant_rd;
        mem_we    = state == INIT || state == UPDATE || (CLEAR_ON_READ && state == READ_RESP && clr_first);
        mem_waddr = state == INIT ? init_ptr : id_q;
        mem_wdata = state == UPDATE ? val_q + STAT_COUNT_WIDTH'(inc_q) : '0;
    end

    assign s_axis_stat_tready = grant_inc;
    assign rd_ready           = grant_rd;
    assign busy               = state == INIT;

    // Counter RAM write port; contents are cleared by the INIT sweep, not by reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Operation sequencer: init sweep, grant, read-modify-write and read response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= INIT;
            init_ptr      <= '0;
            rr_rd         <= 1'b1;
            id_q          <= '0;
            inc_q         <= '0;
            val_q         <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            clr_first     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (&init_ptr) state <= IDLE;
                end
                IDLE: begin
                    if (grant_rd) begin
                        rd_data       <= mem[rd_addr];
                        rd_data_valid <= 1'b1;
                        id_q          <= rd_addr;
                        clr_first     <= 1'b1;
                        rr_rd         <= 1'b0;
                        state         <= READ_RESP;
                    end else if (grant_inc) begin
                        id_q  <= s_axis_stat_tid;
                        inc_q <= s_axis_stat_tdata;
                        val_q <= mem[s_axis_stat_tid];
                        rr_rd <= 1'b1;
                        state <= UPDATE;
                    end
                end
                UPDATE: state <= IDLE;
                READ_RESP: begin
                    clr_first <= 1'b0;
                    if (rd_data_ready) begin
                        rd_data_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_stats_accumulate.sv
// tb_stats_accumulate: scoreboard bench for stats_accumulate (default build and a 20-bit clear-on-read build)
module tb_stats_accumulate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_tdata = '0, b_tdata = '0;
    logic [4:0]  a_tid = '0, b_tid = '0, a_rd_addr = '0, b_rd_addr = '0;
    logic        a_tvalid = 1'b0, b_tvalid = 1'b0, a_rd_valid = 1'b0, b_rd_valid = 1'b0;
    logic        a_rd_data_ready = 1'b1, b_rd_data_ready = 1'b1;
    logic        a_tready, b_tready, a_rd_ready, b_rd_ready;
    logic        a_rd_data_valid, b_rd_data_valid, a_busy, b_busy;
    logic [31:0] a_rd_data;
    logic [19:0] b_rd_data;

    stats_accumulate dut_a (
        .clk(clk), .rst(rst),
        .s_axis_stat_tdata(a_tdata), .s_axis_stat_tid(a_tid),
        .s_axis_stat_tvalid(a_tvalid), .s_axis_stat_tready(a_tready),
        .rd_addr(a_rd_addr), .rd_valid(a_rd_valid), .rd_ready(a_rd_ready),
        .rd_data(a_rd_data), .rd_data_valid(a_rd_data_valid),
        .rd_data_ready(a_rd_data_ready), .busy(a_busy)
    );

    stats_accumulate #(.STAT_COUNT_WIDTH(20), .CLEAR_ON_READ(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_stat_tdata(b_tdata), .s_axis_stat_tid(b_tid),
        .s_axis_stat_tvalid(b_tvalid), .s_axis_stat_tready(b_tready),
        .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .rd_data(b_rd_data), .rd_data_valid(b_rd_data_valid),
        .rd_data_ready(b_rd_data_ready), .busy(b_busy)
    );

    int checks = 0;
    int passes = 0;
    int unsigned model_a [32];
    logic [19:0] model_b [32];
    logic [31:0] qa [$];
    logic [19:0] qb [$];
    bit          log_en = 1'b0;
    bit          grants [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: counters as plain arrays, expected read results queued when a read is accepted
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            for (int i = 0; i < 32; i++) begin
                model_a[i] = 0;
                model_b[i] = '0;
            end
        end else begin
            chk("a_grant_exclusive", {31'b0, a_tready && a_rd_ready}, 32'd0);
            chk("b_grant_exclusive", {31'b0, b_tready && b_rd_ready}, 32'd0);
            if (log_en && (a_tready || a_rd_ready)) grants.push_back(a_rd_ready);
            if (a_tvalid && a_tready) model_a[a_tid] = model_a[a_tid] + 32'(a_tdata);
            if (a_rd_valid && a_rd_ready) qa.push_back(model_a[a_rd_addr]);
            if (a_rd_data_valid && a_rd_data_ready) begin
                if (qa.size() == 0) chk("a_unexpected_resp", 32'd1, 32'd0);
                else chk("a_rd_data", a_rd_data, qa.pop_front());
            end
            if (b_tvalid && b_tready) model_b[b_tid] = model_b[b_tid] + 20'(b_tdata);
            if (b_rd_valid && b_rd_ready) begin
                qb.push_back(model_b[b_rd_addr]);
                model_b[b_rd_addr] = '0;
            end
            if (b_rd_data_valid) begin
                if (qb.size() == 0) chk("b_unexpected_resp", 32'd1, 32'd0);
                else if (b_rd_data_ready) chk("b_rd_data", 32'(b_rd_data), 32'(qb.pop_front()));
                else chk("b_rd_data_hold", 32'(b_rd_data), 32'(qb[0]));
            end
        end
    end

    task automatic a_inc(input logic [4:0] id, input logic [15:0] d);
        bit ok = 1'b0;
        int n = 0;
        a_tid = id; a_tdata = d; a_tvalid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk); ok = a_tready;
            @(posedge clk); #1; n++;
        end
        a_tvalid = 1'b0;
        chk("a_inc_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic a_rd(input logic [4:0] id);
        bit ok = 1'b0;
        int n = 0;
        a_rd_addr = id; a_rd_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk); ok = a_rd_ready;
            @(posedge clk); #1; n++;
        end
        a_rd_valid = 1'b0;
        chk("a_rd_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic b_inc(input logic [4:0] id, input logic [15:0] d);
        bit ok = 1'b0;
        int n = 0;
        b_tid = id; b_tdata = d; b_tvalid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk); ok = b_tready;
            @(posedge clk); #1; n++;
        end
        b_tvalid = 1'b0;
        chk("b_inc_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic b_rd(input logic [4:0] id);
        bit ok = 1'b0;
        int n = 0;
        b_rd_addr = id; b_rd_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk); ok = b_rd_ready;
            @(posedge clk); #1; n++;
        end
        b_rd_valid = 1'b0;
        chk("b_rd_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic reset_dut();
        int n = 0;
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, a_busy}, 32'd1);
        chk("rst_tready", {31'b0, a_tready}, 32'd0);
        chk("rst_rd_ready", {31'b0, a_rd_ready}, 32'd0);
        chk("rst_rd_data_valid", {31'b0, a_rd_data_valid}, 32'd0);
        chk("rst_rd_data", a_rd_data, 32'd0);
        chk("rst_b_rd_data_valid", {31'b0, b_rd_data_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        forever begin
            @(negedge clk);
            if (!a_busy || n >= 200) break;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'd32);
        chk("b_busy_done", {31'b0, b_busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(posedge clk); n++;
        end
        #1;
        chk("drain_empty", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        reset_dut();
        a_rd(5'd0); a_rd(5'd5); a_rd(5'd31);
        a_inc(5'd3, 16'h0010); a_inc(5'd3, 16'hFFFF); a_inc(5'd3, 16'h0001);
        a_rd(5'd3);
        for (int i = 0; i < 16; i++) b_inc(5'd7, 16'hFFFF);
        b_inc(5'd7, 16'h0020);
        b_rd(5'd7);
        b_inc(5'd2, 16'd5);
        b_rd(5'd2);
        b_rd(5'd2);
        b_inc(5'd2, 16'd9);
        b_rd_data_ready = 1'b0;
        b_rd(5'd2);
        repeat (10) @(posedge clk);
        #1 b_rd_data_ready = 1'b1;
        drain();

        reset_dut();
        log_en = 1'b1;
        a_tvalid = 1'b1; a_rd_valid = 1'b1;
        repeat (40) begin
            a_tid = 5'($urandom); a_tdata = 16'($urandom); a_rd_addr = 5'($urandom);
            @(posedge clk); #1;
        end
        a_tvalid = 1'b0; a_rd_valid = 1'b0; log_en = 1'b0;
        chk("grant_count", {31'b0, grants.size() >= 10}, 32'd1);
        if (grants.size() > 0) chk("first_grant_read", {31'b0, grants[0]}, 32'd1);
        for (int i = 1; i < grants.size(); i++) chk("grant_alternates", {31'b0, grants[i] != grants[i-1]}, 32'd1);
        drain();

        repeat (600) begin
            a_tvalid = $urandom_range(0, 2) != 0;
            a_rd_valid = $urandom_range(0, 2) == 0;
            a_tid = 5'($urandom_range(0, 7));
            a_tdata = 16'($urandom);
            a_rd_addr = 5'($urandom_range(0, 7));
            a_rd_data_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        a_tvalid = 1'b0; a_rd_valid = 1'b0; a_rd_data_ready = 1'b1;
        drain();

        a_inc(5'd9, 16'h1234);
        b_inc(5'd9, 16'h0042);
        a_rd_data_ready = 1'b0;
        a_rd(5'd9);
        chk("pre_reset_rd_data_valid", {31'b0, a_rd_data_valid}, 32'd1);
        reset_dut();
        a_rd_data_ready = 1'b1;
        for (int i = 0; i < 32; i++) a_rd(5'(i));
        b_rd(5'd9);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
